acc_csr_ctrl: RTL
=================

// Module: acc_csr_ctrl
// PURPOSE
//  Avalon-MM slave control/status front end for custom_acc_top; sits between the HPS/Nios bus and the core.
//  Software writes CTRL.START; block pulses o_acc_start, times the run until o_acc_finish, latches results.
//  Provides run-cycle count, run counter, watchdog timeout with core abort, optional interrupt.
// PARAMETERS
//  DATA_W      32           CSR data width (bits)
//  ADDR_W      3            word address width (8 word slots)
//  START_LEN   3            o_acc_start high time in clk cycles (>=1)
//  ID_VALUE    32'hACC0_0001 constant returned by ID register
// PORTS
//  clk          in   1       system clock, 50 MHz
//  reset        in   1       synchronous, active-high
//  avs_address  in   ADDR_W  word address
//  avs_read     in   1       read strobe
//  avs_readdata out  DATA_W  read data, valid 1 cycle after avs_read
//  avs_write    in   1       write strobe
//  avs_writedata in  DATA_W  write data
//  o_acc_start  out  1       start pulse to core (i_start)
//  o_acc_reset  out  1       reset to core (reset | abort)
//  i_acc_finish in   1       finish from core (o_finish)
//  o_irq        out  1       level interrupt (ACC_IRQ_EN only)
// BEHAVIOUR
//  Reset: all outputs 0 except o_acc_reset=1; state IDLE; CYCLES/RUNS/flags 0; TLIMIT=0.
//  Map (word): 0 CTRL W: b0 START(w1 pulse) b1 IRQ_ENA b2 CLR(w1: clear DONE,TOUT); R: b1 IRQ_ENA
//   1 STATUS R: b0 BUSY b1 DONE(sticky) b2 TOUT(sticky); 2 CYCLES R; 3 TLIMIT RW; 4 RUNS R; 5 ID R.
//   Unmapped reads 0; unmapped/RO writes ignored. Read latency fixed 1, no waitrequest.
//  FSM IDLE->PULSE->WAIT->IDLE; ABORT 1 cycle.
//   IDLE: write START=1 -> PULSE next cycle, cycle counter cleared to 0, DONE/TOUT cleared.
//   PULSE: o_acc_start=1 for exactly START_LEN cycles, then WAIT.
//   WAIT: counter +1 per cycle; i_acc_finish sampled from first PULSE cycle on.
//   finish seen -> IDLE, CYCLES<=count (cycles from first PULSE cycle to finish, inclusive), DONE=1, RUNS+1.
//   TLIMIT!=0 and count==TLIMIT without finish -> ABORT: o_acc_reset=1 one cycle, TOUT=1, CYCLES<=TLIMIT, ->IDLE.
//  BUSY=1 in PULSE, WAIT, ABORT. START while BUSY ignored (no restart, no flag).
//  TLIMIT=0 disables watchdog. Counter saturates at all-ones; RUNS wraps modulo 2^DATA_W.
//  Same-cycle CLR and DONE/TOUT set: set wins. START+CLR same write: start semantics (flags cleared anyway).
//  finish in same cycle as watchdog expiry: finish wins (DONE, no abort).
//  TLIMIT write while BUSY takes effect immediately (next compare).
//  reset mid-run: immediate return to reset values, core held via o_acc_reset.
// CONFIGURATION
//  ACC_IRQ_EN defined: o_irq = IRQ_ENA & (DONE | TOUT), registered; cleared via CLR or reset.
//  ACC_IRQ_EN undefined: o_irq tied 0, CTRL.b1 reads 0, no IRQ logic synthesised.
// STRUCTURE
//  Package acc_csr_pkg: register word offsets, CTRL/STATUS bit indices, FSM state encoding, ID_VALUE default.
//  One sub-module: acc_run_timer (cycle counter w/ clear, saturate, limit compare -> expired flag).
//  Top keeps Avalon decode, register file, FSM.
// TESTING (bench: acc_csr_ctrl_tb, same clk/reset scheme; core modelled by finish driver)
//  Reset: readback STATUS=0, CYCLES=0, ID=32'hACC0_0001, o_acc_reset=1, o_acc_start=0.
//  Normal run: TLIMIT=0, write CTRL=1, model finish 20 cycles after start rise -> start high 3 cycles,
//   STATUS=2'b10 DONE, CYCLES=21, RUNS=1.
//  Timeout: TLIMIT=50, no finish -> o_acc_reset 1-cycle pulse at count 50, STATUS.TOUT=1, CYCLES=50.
//  START while BUSY: second write during WAIT -> single o_acc_start burst, RUNS=1 after finish.
//  Races: finish on expiry cycle -> DONE=1,TOUT=0; CLR coincident with finish -> DONE=1.
//  ACC_IRQ_EN: IRQ_ENA=1, run completes -> o_irq=1; CLR write -> o_irq=0; without macro o_irq stays 0.

Source files
------------

// File: rtl/acc_csr_pkg.sv
// acc_csr_pkg: register map, CTRL/STATUS bit indices, FSM encoding and ID default for acc_csr_ctrl
package acc_csr_pkg;
    localparam int REG_CTRL   = 0;
    localparam int REG_STATUS = 1;
    localparam int REG_CYCLES = 2;
    localparam int REG_TLIMIT = 3;
    localparam int REG_RUNS   = 4;
    localparam int REG_ID     = 5;
    localparam int CTRL_START   = 0;
    localparam int CTRL_IRQ_ENA = 1;
    localparam int CTRL_CLR     = 2;
    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_TOUT = 2;
    localparam logic [31:0] ID_DEFAULT = 32'hACC0_0001;
    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT, S_ABORT} state_e;
endpackage

// File: rtl/acc_run_timer.sv
// acc_run_timer: saturating run-cycle counter with clear and watchdog limit compare
//  clk, reset   clock, synchronous active-high reset
//  clr_i        restart count (next cycle reports 1)
//  en_i         advance count this cycle
//  limit_i      watchdog limit, 0 disables
//  cnt_o        count of the current cycle (cycles elapsed including this one)
//  expired_o    current count equals a non-zero limit
module acc_run_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] cnt_o,
    output logic         expired_o
);
    logic [W-1:0] cnt_q;
    assign cnt_o     = &cnt_q ? cnt_q : cnt_q + W'(1);
    assign expired_o = (limit_i != '0) && (cnt_o == limit_i);
    always_ff @(posedge clk)
        if (reset || clr_i) cnt_q <= '0;
        else if (en_i) cnt_q <= cnt_o;
endmodule

// File: rtl/acc_csr_ctrl.sv
// acc_csr_ctrl: Avalon-MM CSR front end that starts, times, watchdogs and reports runs of the accelerator core
//  clk, reset                 clock, synchronous active-high reset
//  avs_address/read/readdata  register read, data valid one cycle after avs_read
//  avs_write/writedata        register write
//  o_acc_start                start pulse to core, START_LEN cycles
//  o_acc_reset                core reset: bus reset or watchdog abort
//  i_acc_finish               completion from core
//  o_irq                      level interrupt, only with ACC_IRQ_EN defined (else tied 0)
module acc_csr_ctrl
    import acc_csr_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 3,
    parameter int                START_LEN = 3,
    parameter logic [DATA_W-1:0] ID_VALUE  = ID_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    output logic [DATA_W-1:0] avs_readdata,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic              o_acc_start,
    output logic              o_acc_reset,
    input  logic              i_acc_finish,
    output logic              o_irq
);
    state_e            state_q, state_d;
    logic [DATA_W-1:0] cycles_q, cycles_d, runs_q, runs_d, tlimit_q, tlimit_d, rdata_q;
    logic [DATA_W-1:0] cnt, ctrl_rd, status_rd, rd_mux;
    logic              done_q, done_d, tout_q, tout_d, tmr_clr, tmr_en, expired, busy, wr_ctrl, irq_ena;
    logic              sel_ctrl, sel_status, sel_cycles, sel_tlimit, sel_runs, sel_id;
    assign sel_ctrl   = avs_address == ADDR_W'(REG_CTRL);
    assign sel_status = avs_address == ADDR_W'(REG_STATUS);
    assign sel_cycles = avs_address == ADDR_W'(REG_CYCLES);
    assign sel_tlimit = avs_address == ADDR_W'(REG_TLIMIT);
    assign sel_runs   = avs_address == ADDR_W'(REG_RUNS);
    assign sel_id     = avs_address == ADDR_W'(REG_ID);
    assign wr_ctrl    = avs_write && sel_ctrl;
    assign busy       = state_q != S_IDLE;
    assign o_acc_start  = state_q == S_PULSE;
    assign o_acc_reset  = reset || state_q == S_ABORT;
    assign avs_readdata = rdata_q;
    acc_run_timer #(.W(DATA_W)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .limit_i   (tlimit_q),
        .cnt_o     (cnt),
        .expired_o (expired)
    );
    always_comb begin
        state_d  = state_q;
        cycles_d = cycles_q;
        runs_d   = runs_q;
        tlimit_d = (avs_write && sel_tlimit) ? avs_writedata : tlimit_q;
        done_d   = (wr_ctrl && avs_writedata[CTRL_CLR]) ? 1'b0 : done_q;
        tout_d   = (wr_ctrl && avs_writedata[CTRL_CLR]) ? 1'b0 : tout_q;
        tmr_clr  = 1'b0;
        tmr_en   = 1'b0;
        case (state_q)
            S_IDLE:
                if (wr_ctrl && avs_writedata[CTRL_START]) begin
                    state_d = S_PULSE;
                    tmr_clr = 1'b1;
                    done_d  = 1'b0;
                    tout_d  = 1'b0;
                end
            S_PULSE, S_WAIT: begin
                tmr_en = 1'b1;
                // finish outranks a watchdog expiry in the same cycle
                if (i_acc_finish) begin
                    state_d  = S_IDLE;
                    cycles_d = cnt;
                    done_d   = 1'b1;
                    runs_d   = runs_q + DATA_W'(1);
                end else if (expired) begin
                    state_d  = S_ABORT;
                    cycles_d = tlimit_q;
                    tout_d   = 1'b1;
                end else if (state_q == S_PULSE && cnt == DATA_W'(START_LEN)) begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
`ifdef ACC_IRQ_EN
    logic ena_q, ena_d, irq_q;
    assign ena_d   = wr_ctrl ? avs_writedata[CTRL_IRQ_ENA] : ena_q;
    assign irq_ena = ena_q;
    assign o_irq   = irq_q;
    always_ff @(posedge clk)
        if (reset) begin
            ena_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ena_q <= ena_d;
            irq_q <= ena_d && (done_d || tout_d);
        end
`else
    assign irq_ena = 1'b0;
    assign o_irq   = 1'b0;
`endif
    always_comb begin
        ctrl_rd                = '0;
        ctrl_rd[CTRL_IRQ_ENA]  = irq_ena;
        status_rd              = '0;
        status_rd[ST_BUSY]     = busy;
        status_rd[ST_DONE]     = done_q;
        status_rd[ST_TOUT]     = tout_q;
        rd_mux = sel_ctrl   ? ctrl_rd   :
                 sel_status ? status_rd :
                 sel_cycles ? cycles_q  :
                 sel_tlimit ? tlimit_q  :
                 sel_runs   ? runs_q    :
                 sel_id     ? ID_VALUE  : '0;
    end
    always_ff @(posedge clk)
        if (reset) begin
            state_q  <= S_IDLE;
            cycles_q <= '0;
            runs_q   <= '0;
            tlimit_q <= '0;
            done_q   <= 1'b0;
            tout_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cycles_q <= cycles_d;
            runs_q   <= runs_d;
            tlimit_q <= tlimit_d;
            done_q   <= done_d;
            tout_q   <= tout_d;
            rdata_q  <= avs_read ? rd_mux : '0;
        end
endmodule
